seq_detect_param: RTL and testbench
===================================

Name: seq_detect_param

Overview:
Parametrised serial sequence detector for the CAN controller bit stream. It generalises the fixed 8-bit detector: configurable length, a per-bit don't-care mask, a valid-qualified input, and overlapping or non-overlapping matching. It also counts matches with a saturating counter. It sits after bit de-stuffing and flags programmable bit patterns (e.g. frame markers) to the protocol FSM.

Parameters:
SEQ_LEN, 8, pattern length in bits; legal range 2..32.
CNT_W, 8, width of the saturating match counter.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
load  input  1  starts a pattern load; sampled only in IDLE or DETECT.
din  input  1  serial data bit.
din_valid  input  1  din is consumed on cycles where this is 1.
care_mask  input  SEQ_LEN  bit i = 1 means pattern bit i is compared; 0 means don't-care. Quasi-static.
overlap_en  input  1  1 = overlapping matches allowed; 0 = window restarts after each match.
pat_vld  output  1  a complete pattern is held.
busy  output  1  a pattern load is in progress.
dout  output  1  one-cycle match pulse.
match_cnt  output  CNT_W  number of matches since reset; saturates.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state = IDLE; pattern, history, fill count and bit index all 0; pat_vld = 0, busy = 0, dout = 0, match_cnt = 0. Reset is effective mid-load or mid-detect; a partially loaded pattern is discarded.
- States:
  - IDLE: load = 1 -> LOAD. Stays in IDLE otherwise. Detection is inactive.
  - LOAD: busy = 1. Each valid bit is written to pattern[idx] (LSB first, bit 0 first), then idx increments. The bit with idx = SEQ_LEN-1 completes the load.
    - On completion: pat_vld <= 1, idx <= 0, fill <= 0, history cleared, state -> DETECT (all on the same edge).
    - load is ignored while in LOAD.
    - pat_vld is cleared on entry to LOAD.
  - DETECT: load = 1 -> LOAD. A load has priority over a bit arriving in the same cycle; that bit is not compared.
    - Each valid bit shifts in: history <= {din, history[SEQ_LEN-1:1]}, so history[0] is the oldest bit and aligns with pattern[0].
    - fill increments and saturates at SEQ_LEN.
- Match condition, evaluated on the post-shift window: fill reaches or already is SEQ_LEN, and ((history ^ pattern) & care_mask) == 0.
  - An all-zero care_mask matches every full window.
- Output timing:
  - dout is registered: high for exactly one cycle, on the cycle after the edge that consumes the completing bit. Otherwise 0.
  - dout is never high in IDLE or LOAD.
- After a match:
  - overlap_en = 1: fill stays at SEQ_LEN; the next valid bit may match again. Example: pattern 11, input 111 gives 2 matches.
  - overlap_en = 0: fill <= 0; SEQ_LEN fresh bits are needed before the next match. Same example gives 1 match.
- Cycles with din_valid = 0 change nothing (no shift, no fill change); dout returns to 0.
- match_cnt increments by 1 per match and holds at 2^CNT_W-1. It is not cleared by load.
- Arithmetic: idx and fill are clog2(SEQ_LEN+1) bits wide; no wrap-around is permitted.
- Width changes on care_mask or overlap_en take effect on the next valid bit.

Decomposition:
- Shared package (seq_pkg): state encoding as one-hot localparams (ST_IDLE = 3'b001, ST_LOAD = 3'b010, ST_DETECT = 3'b100), plus a clog2-based width helper.
- One natural sub-module, sat_counter (parameter W; ports inc, q), used for match_cnt. Everything else stays in a single module: one sequential process and one combinational next-state/match process.

Test Plan:
- Load and single match: SEQ_LEN = 8; load, then bits 1,0,1,0,0,1,0,1 (pattern 8'hA5). Then stream 1,0,1,0,0,1,0,1 -> pat_vld = 1; dout pulses once, one cycle after the 8th bit; match_cnt = 1.
- Overlap: SEQ_LEN = 4, pattern 4'b1111, input seven 1s. overlap_en = 1 -> 4 pulses, match_cnt = 4. overlap_en = 0 -> 1 pulse, match_cnt = 1.
- Mask: pattern 8'hA5, care_mask = 8'h0F; stream window 8'hF5 -> match. care_mask = 8'hFF on the same window -> no match.
- Valid gaps: pattern 8'hA5 stream with din_valid low for 3 cycles between bits 4 and 5 -> same single match, delayed 3 cycles; no pulse during the gaps.
- Reset mid-load: assert rst_n = 0 after 5 load bits -> pat_vld = 0, busy = 0, match_cnt = 0 immediately (asynchronous). A subsequent stream yields no dout.
- Reload and saturation: CNT_W = 2, overlap_en = 1, pattern 11, 6 ones -> match_cnt sticks at 3. Assert load together with a valid bit in DETECT -> the bit is not compared; busy = 1 next cycle.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the parametrised sequence detector: one-hot state
// encoding and the counter-width helper.
package seq_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'b001;
  localparam state_t ST_LOAD   = 3'b010;
  localparam state_t ST_DETECT = 3'b100;

  // Width able to hold the values 0..n inclusive.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage : seq_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, holds at all-ones.
// Ports: clk, rst_n (async active-low), inc (count enable), q (count).
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule : sat_counter

// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector for the de-stuffed CAN bit stream.
// A pattern is loaded serially (LSB first), then compared against a sliding
// window of valid input bits under a per-bit care mask.
// Ports: clk, rst_n (async active-low); load starts a pattern load; din and
// din_valid carry the serial stream; care_mask selects compared bits;
// overlap_en allows overlapping matches; pat_vld/busy report load status;
// dout is a one-cycle match pulse; match_cnt is a saturating match count.
module seq_detect_param
  import seq_pkg::*;
#(
  parameter int unsigned SEQ_LEN = 8,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               din,
  input  logic               din_valid,
  input  logic [SEQ_LEN-1:0] care_mask,
  input  logic               overlap_en,
  output logic               pat_vld,
  output logic               busy,
  output logic               dout,
  output logic [CNT_W-1:0]   match_cnt
);

  localparam int unsigned IW = cnt_width(SEQ_LEN);
  localparam logic [IW-1:0] FULL = IW'(SEQ_LEN);
  localparam logic [IW-1:0] LAST = IW'(SEQ_LEN - 1);

  state_t             state, state_n;
  logic [SEQ_LEN-1:0] pattern, pattern_n;
  logic [SEQ_LEN-1:0] history, history_n;
  logic [IW-1:0]      idx, idx_n;
  logic [IW-1:0]      fill, fill_n;
  logic               pat_vld_n, busy_n, dout_n;
  logic               match_inc;

  logic [SEQ_LEN-1:0] hist_sh;
  logic [IW-1:0]      fill_sh;
  logic [SEQ_LEN-1:0] idx_bit;

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      pattern <= '0;
      history <= '0;
      idx     <= '0;
      fill    <= '0;
      pat_vld <= 1'b0;
      busy    <= 1'b0;
      dout    <= 1'b0;
    end else begin
      state   <= state_n;
      pattern <= pattern_n;
      history <= history_n;
      idx     <= idx_n;
      fill    <= fill_n;
      pat_vld <= pat_vld_n;
      busy    <= busy_n;
      dout    <= dout_n;
    end
  end

  // Next-state, pattern load and match evaluation on the post-shift window.
  always_comb begin
    state_n   = state;
    pattern_n = pattern;
    history_n = history;
    idx_n     = idx;
    fill_n    = fill;
    pat_vld_n = pat_vld;
    busy_n    = busy;
    dout_n    = 1'b0;
    match_inc = 1'b0;

    hist_sh = {din, history[SEQ_LEN-1:1]};
    fill_sh = (fill == FULL) ? fill : fill + IW'(1);
    idx_bit = SEQ_LEN'(1) << idx;

    unique case (state)
      ST_IDLE: begin
        if (load) begin
          state_n   = ST_LOAD;
          pat_vld_n = 1'b0;
          busy_n    = 1'b1;
          idx_n     = '0;
        end
      end

      ST_LOAD: begin
        if (din_valid) begin
          // Write via a one-hot mask so idx never needs narrowing.
          pattern_n = din ? (pattern | idx_bit) : (pattern & ~idx_bit);
          if (idx == LAST) begin
            state_n   = ST_DETECT;
            pat_vld_n = 1'b1;
            busy_n    = 1'b0;
            idx_n     = '0;
            fill_n    = '0;
            history_n = '0;
          end else begin
            idx_n = idx + IW'(1);
          end
        end
      end

      ST_DETECT: begin
        // A load wins over a bit arriving in the same cycle.
        if (load) begin
          state_n   = ST_LOAD;
          pat_vld_n = 1'b0;
          busy_n    = 1'b1;
          idx_n     = '0;
        end else if (din_valid) begin
          history_n = hist_sh;
          fill_n    = fill_sh;
          if ((fill_sh == FULL) && (((hist_sh ^ pattern) & care_mask) == '0)) begin
            dout_n    = 1'b1;
            match_inc = 1'b1;
            if (!overlap_en) begin
              fill_n = '0;
            end
          end
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (match_inc),
    .q     (match_cnt)
  );

endmodule : seq_detect_param

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: instance 0 is SEQ_LEN=8/CNT_W=8, instance 1 is
// SEQ_LEN=2/CNT_W=2. Both are compared every cycle against a list-based
// reference model of the detector's rules.
module tb_seq_detect_param;

  logic        clk;
  logic        rst_n;
  logic        ld   [2];
  logic        di   [2];
  logic        dv   [2];
  logic        ov   [2];
  logic [31:0] msk  [2];
  logic        pv_o [2];
  logic        bz_o [2];
  logic        do_o [2];
  logic [7:0]  cnt_a;
  logic [1:0]  cnt_b;

  int total = 0;
  int bad   = 0;

  // Reference model state (mode 0 = idle, 1 = loading, 2 = detecting).
  int len  [2] = '{8, 2};
  int cmax [2] = '{255, 3};
  int mode [2];
  bit pat  [2][32];
  bit win  [2][32];
  int pidx [2];
  int wn   [2];
  int cnt  [2];
  bit e_pv [2];
  bit e_bz [2];
  bit e_do [2];

  seq_detect_param #(.SEQ_LEN(8), .CNT_W(8)) u_dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (ld[0]),
    .din        (di[0]),
    .din_valid  (dv[0]),
    .care_mask  (msk[0][7:0]),
    .overlap_en (ov[0]),
    .pat_vld    (pv_o[0]),
    .busy       (bz_o[0]),
    .dout       (do_o[0]),
    .match_cnt  (cnt_a)
  );

  seq_detect_param #(.SEQ_LEN(2), .CNT_W(2)) u_dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (ld[1]),
    .din        (di[1]),
    .din_valid  (dv[1]),
    .care_mask  (msk[1][1:0]),
    .overlap_en (ov[1]),
    .pat_vld    (pv_o[1]),
    .busy       (bz_o[1]),
    .dout       (do_o[1]),
    .match_cnt  (cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset(input int k);
    mode[k] = 0; pidx[k] = 0; wn[k] = 0; cnt[k] = 0;
    e_pv[k] = 1'b0; e_bz[k] = 1'b0; e_do[k] = 1'b0;
    for (int i = 0; i < 32; i++) begin
      pat[k][i] = 1'b0;
      win[k][i] = 1'b0;
    end
  endfunction

  function automatic bit window_hits(input int k);
    for (int i = 0; i < len[k]; i++)
      if (msk[k][i] && (win[k][i] != pat[k][i])) return 1'b0;
    return 1'b1;
  endfunction

  // One clock edge of the detector, described by its rules.
  function automatic void model_step(input int k);
    e_do[k] = 1'b0;
    if (mode[k] == 0) begin
      if (ld[k]) begin
        mode[k] = 1; pidx[k] = 0; e_pv[k] = 1'b0; e_bz[k] = 1'b1;
      end
    end else if (mode[k] == 1) begin
      if (dv[k]) begin
        pat[k][pidx[k]] = di[k];
        pidx[k]++;
        if (pidx[k] == len[k]) begin
          mode[k] = 2; wn[k] = 0; e_pv[k] = 1'b1; e_bz[k] = 1'b0;
        end
      end
    end else begin
      if (ld[k]) begin
        mode[k] = 1; pidx[k] = 0; e_pv[k] = 1'b0; e_bz[k] = 1'b1;
      end else if (dv[k]) begin
        // Drop the oldest bit, append the newest at the top.
        for (int i = 0; i < len[k] - 1; i++) win[k][i] = win[k][i+1];
        win[k][len[k]-1] = di[k];
        if (wn[k] < len[k]) wn[k]++;
        if (wn[k] == len[k] && window_hits(k)) begin
          e_do[k] = 1'b1;
          if (cnt[k] < cmax[k]) cnt[k]++;
          if (!ov[k]) wn[k] = 0;
        end
      end
    end
  endfunction

  task automatic compare_all();
    chk("a_pat_vld", pv_o[0], e_pv[0]);
    chk("a_busy",    bz_o[0], e_bz[0]);
    chk("a_dout",    do_o[0], e_do[0]);
    chk("a_cnt",     cnt_a,   cnt[0]);
    chk("b_pat_vld", pv_o[1], e_pv[1]);
    chk("b_busy",    bz_o[1], e_bz[1]);
    chk("b_dout",    do_o[1], e_do[1]);
    chk("b_cnt",     cnt_b,   cnt[1]);
  endtask

  // Advance one clock: inputs are already set; outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    for (int k = 0; k < 2; k++) begin
      ld[k] = 1'b0; dv[k] = 1'b0; di[k] = 1'b0;
    end
  endtask

  task automatic send(input int k, input bit b);
    dv[k] = 1'b1; di[k] = b;
    tick();
    dv[k] = 1'b0;
  endtask

  task automatic send_word(input int k, input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) send(k, w[i]);
  endtask

  task automatic load_pat(input int k, input logic [31:0] w, input int n);
    ld[k] = 1'b1;
    tick();
    ld[k] = 1'b0;
    send_word(k, w, n);
  endtask

  initial begin
    logic [31:0] w;
    int          a_start;

    rst_n = 1'b0;
    idle_inputs();
    ov[0] = 1'b1; ov[1] = 1'b1;
    msk[0] = 32'hFF; msk[1] = 32'h3;
    model_reset(0);
    model_reset(1);
    #12;
    compare_all();
    rst_n = 1'b1;
    tick();

    // Load A5 and stream it back once.
    load_pat(0, 32'hA5, 8);
    chk("a5_loaded", pv_o[0], 1);
    a_start = cnt[0];
    send_word(0, 32'hA5, 8);
    chk("a5_pulse", do_o[0], 1);
    tick();
    chk("a5_pulse_drop", do_o[0], 0);

    // Same stream with a three-cycle valid gap between bits 4 and 5.
    w = 32'hA5;
    send_word(0, w, 4);
    repeat (3) begin
      tick();
      chk("gap_quiet", do_o[0], 0);
    end
    for (int i = 4; i < 8; i++) send(0, w[i]);
    chk("gap_pulse", do_o[0], 1);

    // Mask: low nibble only, window F5 matches; full mask on F5 does not.
    msk[0] = 32'h0F;
    send_word(0, 32'hF5, 8);
    chk("mask_hit", do_o[0], 1);
    msk[0] = 32'hFF;
    send_word(0, 32'hF5, 8);
    chk("mask_miss", do_o[0], 0);
    chk("a_cnt_after_mask", cnt_a, a_start + 3);

    // Overlap on the 8-bit instance: all-ones pattern, ten ones.
    load_pat(0, 32'hFF, 8);
    ov[0] = 1'b1;
    send_word(0, 32'h3FF, 10);
    ov[0] = 1'b0;
    send_word(0, 32'h3FF, 10);
    ov[0] = 1'b1;

    // Short pattern 11, six ones with overlap: counter saturates at 3.
    load_pat(1, 32'h3, 2);
    send_word(1, 32'h3F, 6);
    chk("b_saturate", cnt_b, 3);

    // Load together with a valid bit in DETECT: bit ignored, busy next cycle.
    ld[1] = 1'b1; dv[1] = 1'b1; di[1] = 1'b1;
    tick();
    chk("b_load_prio_busy", bz_o[1], 1);
    chk("b_load_prio_dout", do_o[1], 0);
    idle_inputs();
    send_word(1, 32'h1, 2);

    // Randomised traffic on both instances.
    for (int n = 0; n < 1500; n++) begin
      for (int k = 0; k < 2; k++) begin
        ld[k] = ($urandom_range(0, 60) == 0);
        dv[k] = ($urandom_range(0, 3) != 0);
        di[k] = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 20) == 0) ov[k] = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 50) == 0) msk[k] = $urandom & $urandom & $urandom;
      end
      tick();
    end
    idle_inputs();
    msk[0] = 32'hFF;
    msk[1] = 32'h3;

    // Asynchronous reset part-way through a load.
    ld[0] = 1'b1;
    tick();
    ld[0] = 1'b0;
    send_word(0, 32'h15, 5);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset(0);
    model_reset(1);
    chk("rst_pat_vld", pv_o[0], 0);
    chk("rst_busy",    bz_o[0], 0);
    chk("rst_cnt",     cnt_a,   0);
    #3;
    rst_n = 1'b1;
    send_word(0, 32'hA5, 8);
    send_word(0, 32'hA5, 8);
    chk("post_rst_cnt", cnt_a, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_seq_detect_param
